lsu_fsm: RTL and testbench
==========================

Name: lsu_fsm

Overview:
Load/store unit sitting directly upstream of the byte-addressed data memory (11-bit address, func3-encoded size, combinational read, negedge write). Accepts one load/store request from the execute stage over a valid/ready handshake. Checks alignment, range and func3 legality, then drives the memory port for exactly one access cycle. Returns the load data or an error on a one-cycle response strobe.

Parameters:
ADDR_W, 11, memory address width; memory span is 2**ADDR_W bytes.
DATA_W, 32, data width; fixed at 32, present for documentation only.

Ports:
clk  in  1  system clock, rising-edge state updates
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  LSU can accept a request (IDLE only)
req_we  in  1  1=store, 0=load
req_func3  in  3  RV32I load/store func3
req_addr  in  32  byte address from ALU
req_wdata  in  32  store data
rsp_valid  out  1  one-cycle response strobe
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_err  out  1  access rejected (misaligned, out of range, illegal func3)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  32  memory write data
mem_func3  out  3  memory size/sign code
mem_rd_en  out  1  memory read enable
mem_wr_en  out  1  memory write enable

Behaviour:
- States: IDLE, ACCESS, RESP (plus SPLIT under the optional feature). Reset → IDLE.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, mem_func3=0.
- req_ready=1 only in IDLE with rst low. Handshake completes on req_valid & req_ready at a rising edge; all req_* fields are latched then.
- Checks on acceptance, using the latched fields:
  - Illegal func3: loads 3/6/7; stores 3..7.
  - Misaligned: halfword with addr[0]=1; word with addr[1:0]≠0.
  - Range error: addr+size−1 ≥ 2**ADDR_W. Any set upper bit counts; arithmetic is 33-bit, so no wrap-around.
- Any check failing → RESP with rsp_err=1 and rsp_rdata=0. The memory is never enabled.
- Otherwise → ACCESS for exactly one cycle:
  - mem_addr = addr[ADDR_W-1:0], mem_func3 = func3, mem_wdata = wdata.
  - Load: mem_rd_en=1, and mem_rdata is captured into rsp_rdata at the closing edge.
  - Store: mem_wr_en=1; the memory commits at the mid-cycle negedge.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_rdata and rsp_err hold until the next RESP. There is no response backpressure.
- Latency: accept at edge T → rsp_valid high in cycle T+2. Throughput is one request per 3 cycles; req_ready returns in cycle T+3.
- Memory enables are 0 in all states other than ACCESS/SPLIT.
- mem_wr_en is gated by !rst, so reset asserted during ACCESS suppresses the write. Reset at any point aborts to IDLE with no response.
- Requests presented while req_ready=0 are ignored; the upstream stage must hold them.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN.
- Defined: in-range misaligned accesses are not errors. They enter SPLIT:
  - One byte access per cycle for size N = 2 or 4, with byte counter k = 0..N−1.
  - Each access uses mem_addr = addr+k and mem_func3 = LBU (load) or SB (store).
  - Loads assemble bytes little-endian into a holding register. After the last byte, sign- or zero-extend per the original func3.
  - Then RESP. Latency = N+1 cycles after acceptance.
  - Reset mid-split leaves earlier bytes written; this is documented, not an error.
- Undefined: misalignment sets rsp_err as above and the SPLIT state is absent.

Decomposition:
- Shared package lsu_pkg:
  - State enum.
  - Load func3 constants: LB=0, LH=1, LW=2, LBU=4, LHU=5.
  - Store func3 constants: SB=0, SH=1, SW=2.
  - A size-from-func3 function and the error-cause encoding.
- The load/store func3 enums stay consistent with rv_dec.svh.
- One combinational sub-module, lsu_chk: takes func3, we, addr; outputs misaligned, out_of_range, illegal.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 → store rsp_valid at T+2, rsp_err=0; load rsp_rdata=0xDEADBEEF, bytes 0x10..0x13 = EF BE AD DE.
- SB 0x20=0x80, then LB 0x20 → 0xFFFFFF80; LBU 0x20 → 0x00000080; LHU 0x20 with 0x21=0x00 → 0x00000080.
- LW 0x7FE → rsp_err=1, mem_rd_en never asserted. SW addr=0x00001000 → rsp_err=1, memory unchanged.
- LH 0x31 → without macro, rsp_err=1. With LSU_MISALIGN_SPLIT_EN and bytes 0x31=0x34, 0x32=0xF2 → rsp_rdata=0xFFFFF234, rsp_valid at T+3.
- Load with func3=3 → rsp_err=1. Back-to-back req_valid held high → req_ready low in cycles T+1 and T+2, second request accepted at T+3.
- SW issued and rst raised during ACCESS → mem_wr_en=0, no rsp_valid, memory unchanged, state IDLE after reset.

Source files
------------

// File: rtl/lsu_fsm_pkg.sv
// Shared LSU types: FSM states, RV32I load/store func3 codes, size helper.
// SPLIT exists only when LSU_MISALIGN_SPLIT_EN is defined.
package lsu_pkg;

  localparam int DATA_W = 32;

`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP,
    S_SPLIT
  } lsu_state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } lsu_state_e;
`endif

  // Encodings match the func3 fields used by rv_dec.svh
  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } ld_f3_e;

  typedef enum logic [2:0] {
    SB = 3'd0,
    SH = 3'd1,
    SW = 3'd2
  } st_f3_e;

  typedef struct packed {
    logic illegal;
    logic misaligned;
    logic out_of_range;
  } lsu_err_t;

  function automatic logic [2:0] f3_size(input logic [2:0] f3);
    logic [2:0] s;
    s = 3'd4;
    unique case (f3[1:0])
      2'd0:    s = 3'd1;
      2'd1:    s = 3'd2;
      default: s = 3'd4;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lsu_fsm_if.sv
// LSU bus bundle: execute-stage request/response plus data-memory port.
// master = execute stage + memory side, slave = LSU.
interface lsu_fsm_if #(
  parameter int ADDR_W = 11
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_func3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        mem_func3;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_we, req_func3,
    output req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_addr, mem_wdata,
    input  mem_func3, mem_rd_en, mem_wr_en
  );

  modport slave (
    input  req_valid, req_we, req_func3,
    input  req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_addr, mem_wdata,
    output mem_func3, mem_rd_en, mem_wr_en
  );
endinterface

// File: rtl/lsu_fsm_chk.sv
// Combinational request checker: func3 legality, alignment, range.
// Range uses 33-bit end address so large addresses never wrap.
module lsu_chk
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [2:0]  i_func3,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  output logic        o_misaligned,
  output logic        o_out_of_range,
  output logic        o_illegal
);
  logic [2:0]  w_size;
  logic [32:0] w_end;

  assign w_size = f3_size(i_func3);
  assign w_end  = {1'b0, i_addr} + {30'd0, w_size} - 33'd1;

  assign o_out_of_range = |w_end[32:ADDR_W];

  always_comb begin
    o_illegal = 1'b0;
    if (i_we)
      o_illegal = (i_func3 > 3'd2);
    else
      o_illegal = (i_func3 == 3'd3) || (i_func3[2:1] == 2'b11);
  end

  always_comb begin
    o_misaligned = 1'b0;
    unique case (1'b1)
      (w_size == 3'd2): o_misaligned = i_addr[0];
      (w_size == 3'd4): o_misaligned = |i_addr[1:0];
      default:          o_misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_fsm.sv
// Load/store unit FSM: one request, one memory access, one response strobe.
// LSU_MISALIGN_SPLIT_EN turns in-range misaligned accesses into byte splits.
module lsu_fsm
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      rst,
  lsu_fsm_if.slave bus
);
  lsu_state_e        r_state;
  lsu_state_e        w_nxt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic              w_mis;
  logic              w_oor;
  logic              w_ill;
  logic              w_bad;
  logic              w_ready;
  logic              w_acc;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_maddr;
  logic [2:0]        w_mf3;
  logic [DATA_W-1:0] w_mwdata;

  lsu_chk #(.ADDR_W(ADDR_W)) u_chk (
    .i_func3        (bus.req_func3),
    .i_we           (bus.req_we),
    .i_addr         (bus.req_addr),
    .o_misaligned   (w_mis),
    .o_out_of_range (w_oor),
    .o_illegal      (w_ill)
  );

  assign w_acc = bus.req_valid & w_ready;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]  r_k;
  logic [31:0] r_hold;
  logic [31:0] w_asm;
  logic [31:0] w_ext;
  logic        w_last;

  assign w_bad  = w_ill | w_oor;
  assign w_last = ({1'b0, r_k} == (f3_size(r_f3) - 3'd1));

  always_comb begin
    w_asm = r_hold;
    w_asm[{r_k, 3'b000} +: 8] = bus.mem_rdata[7:0];
  end

  always_comb begin
    w_ext = w_asm;
    unique case (1'b1)
      (r_f3 == LH):  w_ext = {{16{w_asm[15]}}, w_asm[15:0]};
      (r_f3 == LHU): w_ext = {16'd0, w_asm[15:0]};
      default:       w_ext = w_asm;
    endcase
  end
`else
  assign w_bad = w_ill | w_oor | w_mis;
`endif

  always_comb begin
    w_nxt    = r_state;
    w_ready  = 1'b0;
    w_rd     = 1'b0;
    w_wr     = 1'b0;
    w_maddr  = r_addr;
    w_mf3    = r_f3;
    w_mwdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        w_ready = ~rst;
        if (bus.req_valid && !rst) begin
          if (w_bad)
            w_nxt = S_RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (w_mis)
            w_nxt = S_SPLIT;
`endif
          else
            w_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_rd  = ~r_we;
        w_wr  = r_we;
        w_nxt = S_RESP;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      // One byte lane per cycle, data shifted down to lane 0
      S_SPLIT: begin
        w_rd     = ~r_we;
        w_wr     = r_we;
        w_maddr  = r_addr + ADDR_W'(r_k);
        w_mf3    = r_we ? SB : LBU;
        w_mwdata = r_wdata >> {r_k, 3'b000};
        if (w_last)
          w_nxt = S_RESP;
      end
`endif
      S_RESP:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      r_k     <= '0;
      r_hold  <= '0;
`endif
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_func3;
        r_addr  <= bus.req_addr[ADDR_W-1:0];
        r_wdata <= bus.req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
        r_k     <= '0;
        r_hold  <= '0;
`endif
        if (w_bad) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
      if (r_state == S_ACCESS) begin
        r_err   <= 1'b0;
        r_rdata <= r_we ? '0 : bus.mem_rdata;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      if (r_state == S_SPLIT) begin
        r_k    <= r_k + 2'd1;
        r_hold <= w_asm;
        if (w_last) begin
          r_err   <= 1'b0;
          r_rdata <= r_we ? '0 : w_ext;
        end
      end
`endif
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = (r_state == S_RESP) & ~rst;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;
  assign bus.mem_addr  = w_maddr;
  assign bus.mem_wdata = w_mwdata;
  assign bus.mem_func3 = w_mf3;
  assign bus.mem_rd_en = w_rd & ~rst;
  assign bus.mem_wr_en = w_wr & ~rst;

endmodule

// File: tb/tb_lsu_fsm.sv
// Directed bench for lsu_fsm with a byte-array data memory model.
// Build with LSU_MISALIGN_SPLIT_EN to exercise the split path.
module tb_lsu_fsm;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  logic [7:0] mem [0:2047];
  logic [7:0] b0, b1, b2, b3;

  lsu_fsm_if #(.ADDR_W(11)) bus ();

  lsu_fsm #(.ADDR_W(11), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign b0 = mem[bus.mem_addr];
  assign b1 = mem[bus.mem_addr + 11'd1];
  assign b2 = mem[bus.mem_addr + 11'd2];
  assign b3 = mem[bus.mem_addr + 11'd3];

  always_comb begin
    bus.mem_rdata = '0;
    case (bus.mem_func3)
      3'd0: bus.mem_rdata = {{24{b0[7]}}, b0};
      3'd1: bus.mem_rdata = {{16{b1[7]}}, b1, b0};
      3'd2: bus.mem_rdata = {b3, b2, b1, b0};
      3'd4: bus.mem_rdata = {24'd0, b0};
      3'd5: bus.mem_rdata = {16'd0, b1, b0};
      default: bus.mem_rdata = '0;
    endcase
  end

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      mem[bus.mem_addr] = bus.mem_wdata[7:0];
      if (bus.mem_func3 == 3'd1 || bus.mem_func3 == 3'd2)
        mem[bus.mem_addr + 11'd1] = bus.mem_wdata[15:8];
      if (bus.mem_func3 == 3'd2) begin
        mem[bus.mem_addr + 11'd2] = bus.mem_wdata[23:16];
        mem[bus.mem_addr + 11'd3] = bus.mem_wdata[31:24];
      end
    end
  end

  function automatic logic [31:0] mword(input logic [10:0] a);
    return {mem[a + 11'd3], mem[a + 11'd2], mem[a + 11'd1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response strobe
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output logic saw_rd,
                        output logic saw_wr);
    int n;
    n = 0;
    while (!bus.req_ready && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_func3 = f3;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat    = 0;
    saw_rd = 1'b0;
    saw_wr = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      saw_rd = saw_rd | bus.mem_rd_en;
      saw_wr = saw_wr | bus.mem_wr_en;
      if (bus.rsp_valid) begin
        lat = i;
        break;
      end
      @(posedge clk);
      #1;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    if (lat == 0)
      check("rsp_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        srd;
    logic        swr;
    logic        seen;

    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_rsp", {29'd0, bus.rsp_valid, bus.mem_rd_en,
                      bus.mem_wr_en}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err", {31'd0, bus.rsp_err}, 32'd0);
    check("rst_maddr", {21'd0, bus.mem_addr}, 32'd0);
    check("rst_mwdata", bus.mem_wdata, 32'd0);
    check("rst_mf3", {29'd0, bus.mem_func3}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_ready", {31'd0, bus.req_ready}, 32'd1);

    // SW then LW at 0x10
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, er, lat, srd, swr);
    check("sw_lat", lat, 32'd2);
    check("sw_err", {31'd0, er}, 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_mem", mword(11'h10), 32'hDEADBEEF);
    check("sw_b0", {24'd0, mem[11'h10]}, 32'hEF);
    do_req(1'b0, 3'd2, 32'h10, 32'h0, rd, er, lat, srd, swr);
    check("lw_lat", lat, 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {31'd0, er}, 32'd0);

    // Byte store and sign/zero-extended loads
    do_req(1'b1, 3'd0, 32'h20, 32'h12345680, rd, er, lat, srd, swr);
    check("sb_mem", mword(11'h20), 32'h00000080);
    do_req(1'b0, 3'd0, 32'h20, 32'h0, rd, er, lat, srd, swr);
    check("lb_rdata", rd, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h20, 32'h0, rd, er, lat, srd, swr);
    check("lbu_rdata", rd, 32'h00000080);
    do_req(1'b0, 3'd5, 32'h20, 32'h0, rd, er, lat, srd, swr);
    check("lhu_rdata", rd, 32'h00000080);

    // Range errors and last legal word
    do_req(1'b0, 3'd2, 32'h7FE, 32'h0, rd, er, lat, srd, swr);
    check("lw7fe_err", {31'd0, er}, 32'd1);
    check("lw7fe_rd", {31'd0, srd}, 32'd0);
    check("lw7fe_rdata", rd, 32'd0);
    do_req(1'b1, 3'd2, 32'h1000, 32'hA5A5A5A5, rd, er, lat, srd, swr);
    check("sw1000_err", {31'd0, er}, 32'd1);
    check("sw1000_wr", {31'd0, swr}, 32'd0);
    check("sw1000_mem", mword(11'h0), 32'd0);
    mem[11'h7FC] = 8'h11;
    mem[11'h7FD] = 8'h22;
    mem[11'h7FE] = 8'h33;
    mem[11'h7FF] = 8'h44;
    do_req(1'b0, 3'd2, 32'h7FC, 32'h0, rd, er, lat, srd, swr);
    check("lw7fc_err", {31'd0, er}, 32'd0);
    check("lw7fc_rdata", rd, 32'h44332211);

    // Misaligned halfword load
    mem[11'h31] = 8'h34;
    mem[11'h32] = 8'hF2;
    do_req(1'b0, 3'd1, 32'h31, 32'h0, rd, er, lat, srd, swr);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("lh31_err", {31'd0, er}, 32'd0);
    check("lh31_rdata", rd, 32'hFFFFF234);
    check("lh31_lat", lat, 32'd3);
`else
    check("lh31_err", {31'd0, er}, 32'd1);
    check("lh31_rdata", rd, 32'd0);
    check("lh31_rd", {31'd0, srd}, 32'd0);
`endif

    // Misaligned word store
    do_req(1'b1, 3'd2, 32'h41, 32'h11223344, rd, er, lat, srd, swr);
`ifdef LSU_MISALIGN_SPLIT_EN
    check("sw41_err", {31'd0, er}, 32'd0);
    check("sw41_lat", lat, 32'd5);
    check("sw41_mem", mword(11'h41), 32'h11223344);
`else
    check("sw41_err", {31'd0, er}, 32'd1);
    check("sw41_mem", mword(11'h41), 32'd0);
`endif

    // Illegal func3
    do_req(1'b0, 3'd3, 32'h10, 32'h0, rd, er, lat, srd, swr);
    check("ld3_err", {31'd0, er}, 32'd1);
    do_req(1'b1, 3'd5, 32'h60, 32'hFFFFFFFF, rd, er, lat, srd, swr);
    check("st5_err", {31'd0, er}, 32'd1);
    check("st5_mem", mword(11'h60), 32'd0);
    do_req(1'b0, 3'd4, 32'h10, 32'h0, rd, er, lat, srd, swr);
    check("err_clear", {31'd0, er}, 32'd0);
    check("lbu10_rdata", rd, 32'h000000EF);

    // Back-to-back: req_valid held high across two requests
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_func3 = 3'd4;
    bus.req_addr  = 32'h13;
    @(posedge clk);
    #1;
    check("b2b_rdy1", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b_rdy2", {31'd0, bus.req_ready}, 32'd0);
    check("b2b_rsp1", {31'd0, bus.rsp_valid}, 32'd1);
    check("b2b_data1", bus.rsp_rdata, 32'h000000DE);
    @(posedge clk);
    #1;
    check("b2b_rdy3", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("b2b_acc2", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("b2b_rsp2", {31'd0, bus.rsp_valid}, 32'd1);
    @(posedge clk);
    #1;

    // Reset raised during a store ACCESS cycle
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_func3 = 3'd2;
    bus.req_addr  = 32'h50;
    bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rA_wr_pre", {31'd0, bus.mem_wr_en}, 32'd1);
    rst = 1'b1;
    #1;
    check("rA_wr_gate", {31'd0, bus.mem_wr_en}, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 1'b0;
    #1;
    check("rA_idle", {31'd0, bus.req_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      seen = seen | bus.rsp_valid;
      @(posedge clk);
      #1;
    end
    check("rA_norsp", {31'd0, seen}, 32'd0);
    check("rA_mem", mword(11'h50), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
